// File: rtl/uart_img_pkg.sv
// Shared constants and state type for the UART image receive path
// (packer, rx RAM and image pipeline).
package uart_img_pkg;
   localparam int PIXELS = 240*176;
   localparam int ADDR_W = $clog2(PIXELS);
   localparam logic [7:0] SYNC0 = 8'hAA;
   localparam logic [7:0] SYNC1 = 8'h55;

   typedef enum logic [1:0] {
      SYNC0_WAIT,
      SYNC1_WAIT,
      PIXEL
   } rx_state_t;
endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle counter: flags expiry on the cycle the count would reach
// TIMEOUT_CYC, so the owner can react on that same edge.
module rx_idle_timer #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

   logic [TW-1:0] cnt;

   // clear beats expiry, so a byte landing on the last idle cycle is kept
   assign expired = enable && !clear && (cnt >= LIMIT - TW'(1));

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (enable && cnt != LIMIT)
         cnt <= cnt + TW'(1);
   end
endmodule

// File: rtl/rx_pixel_packer.sv
// Receive image RAM writer: hunts for the 2-byte sync header, then packs
// RGB byte triplets into 24-bit pixels written at incrementing addresses.
module rx_pixel_packer
   import uart_img_pkg::*;
#(
   parameter int         PIXELS      = uart_img_pkg::PIXELS,
   parameter int         ADDR_W      = $clog2(PIXELS),
   parameter logic [7:0] SYNC0       = uart_img_pkg::SYNC0,
   parameter logic [7:0] SYNC1       = uart_img_pkg::SYNC1,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   output logic              we,
   output logic [23:0]       wData,
   output logic [ADDR_W-1:0] wAddr,
   output logic              frame_done,
   output logic              busy,
   output logic              timeout_err
);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS-1);

   rx_state_t         state, state_n;
   logic [1:0]        byte_idx, byte_idx_n;
   logic [ADDR_W-1:0] pixel_cnt, pixel_cnt_n;
   logic [7:0]        r_hold, r_hold_n, g_hold, g_hold_n;
   logic              we_n, last_flag, last_flag_n, timeout_n;
   logic [23:0]       wdata_n;
   logic [ADDR_W-1:0] waddr_n;
   logic              tmr_expired;

   assign busy = (state != SYNC0_WAIT);

   rx_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (busy),
      .clear   (rx_done || !busy),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= SYNC0_WAIT;
      else
         state <= state_n;
   end

   always_comb begin
      state_n     = state;
      byte_idx_n  = byte_idx;
      pixel_cnt_n = pixel_cnt;
      r_hold_n    = r_hold;
      g_hold_n    = g_hold;
      we_n        = 1'b0;
      wdata_n     = wData;
      waddr_n     = wAddr;
      last_flag_n = 1'b0;
      timeout_n   = 1'b0;
      if (rx_done) begin
         unique case (state)
            SYNC0_WAIT: begin
               if (rx_data == SYNC0) state_n = SYNC1_WAIT;
            end
            SYNC1_WAIT: begin
               if (rx_data == SYNC1) begin
                  state_n     = PIXEL;
                  byte_idx_n  = 2'd0;
                  pixel_cnt_n = '0;
               end else if (rx_data != SYNC0) begin
                  state_n = SYNC0_WAIT;
               end
            end
            PIXEL: begin
               // header values are plain data here
               unique case (byte_idx)
                  2'd0: begin
                     r_hold_n   = rx_data;
                     byte_idx_n = 2'd1;
                  end
                  2'd1: begin
                     g_hold_n   = rx_data;
                     byte_idx_n = 2'd2;
                  end
                  default: begin
                     we_n       = 1'b1;
                     wdata_n    = {r_hold, g_hold, rx_data};
                     waddr_n    = pixel_cnt;
                     byte_idx_n = 2'd0;
                     if (pixel_cnt == LAST_PIX) begin
                        pixel_cnt_n = '0;
                        state_n     = SYNC0_WAIT;
                        last_flag_n = 1'b1;
                     end else begin
                        pixel_cnt_n = pixel_cnt + ADDR_W'(1);
                     end
                  end
               endcase
            end
            default: state_n = SYNC0_WAIT;
         endcase
      end else if (tmr_expired) begin
         state_n     = SYNC0_WAIT;
         byte_idx_n  = 2'd0;
         pixel_cnt_n = '0;
         timeout_n   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx    <= 2'd0;
         pixel_cnt   <= '0;
         r_hold      <= 8'd0;
         g_hold      <= 8'd0;
         we          <= 1'b0;
         wData       <= 24'd0;
         wAddr       <= '0;
         last_flag   <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         byte_idx    <= byte_idx_n;
         pixel_cnt   <= pixel_cnt_n;
         r_hold      <= r_hold_n;
         g_hold      <= g_hold_n;
         we          <= we_n;
         wData       <= wdata_n;
         wAddr       <= waddr_n;
         last_flag   <= last_flag_n;
         frame_done  <= last_flag;
         timeout_err <= timeout_n;
      end
   end
endmodule
